// File: rtl/alu_functional_unit.sv
// rtl/alu_functional_unit.sv - integer ALU with one-cycle execute stage and result FIFO feeding the CDB
// Occupancy-based busy leaves room for the one beat the reservation station may already have in flight.
module alu_functional_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_IX_WIDTH = 3,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   rval1_in,
  input  logic [DATA_WIDTH-1:0]   rval2_in,
  input  logic [3:0]              opcode_in,
  input  logic [ROB_IX_WIDTH-1:0] rob_ix_in,
  output logic                    busy_out,
  output logic                    cdb_req_out,
  input  logic                    cdb_grant_in,
  output logic [ROB_IX_WIDTH-1:0] cdb_rob_ix_out,
  output logic [DATA_WIDTH-1:0]   cdb_value_out,
  output logic                    overflow_err_out
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic                    e_valid_q, e_valid_d;
  logic [DATA_WIDTH-1:0]   e_a_q, e_a_d, e_b_q, e_b_d;
  logic [3:0]              e_op_q, e_op_d;
  logic [ROB_IX_WIDTH-1:0] e_rob_q, e_rob_d;
  logic [DATA_WIDTH-1:0]   val_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   val_d [FIFO_DEPTH];
  logic [ROB_IX_WIDTH-1:0] rob_q [FIFO_DEPTH];
  logic [ROB_IX_WIDTH-1:0] rob_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0]   result;
  logic [4:0]              shamt;
  logic                    pop, e_adv, accept;
  logic [OW-1:0]           occ_in;

  assign shamt = e_b_q[4:0];

  always_comb begin
    result = '0;
    case (e_op_q)
      4'd0: result = e_a_q + e_b_q;
      4'd1: result = e_a_q - e_b_q;
      4'd2: result = e_a_q & e_b_q;
      4'd3: result = e_a_q | e_b_q;
      4'd4: result = e_a_q ^ e_b_q;
      4'd5: result = {{(DATA_WIDTH-1){1'b0}}, ($signed(e_a_q) < $signed(e_b_q))};
      4'd6: result = {{(DATA_WIDTH-1){1'b0}}, (e_a_q < e_b_q)};
      4'd7: result = e_a_q << shamt;
      4'd8: result = e_a_q >> shamt;
      4'd9: result = $signed(e_a_q) >>> shamt;
      default: result = '0;
    endcase
  end

  assign cdb_req_out      = (count_q != '0);
  assign pop              = cdb_req_out && cdb_grant_in;
  assign e_adv            = e_valid_q && ((count_q < DEPTH_C) || pop);
  assign accept           = valid_in && (!e_valid_q || e_adv);
  assign occ_in           = OW'(count_q) + OW'(e_valid_q) + OW'(valid_in);
  assign busy_out         = (occ_in >= OW'(FIFO_DEPTH));
  assign cdb_rob_ix_out   = cdb_req_out ? rob_q[rd_ptr_q] : '0;
  assign cdb_value_out    = cdb_req_out ? val_q[rd_ptr_q] : '0;
  assign overflow_err_out = ovf_q;

  always_comb begin
    e_valid_d = e_valid_q;
    e_a_d     = e_a_q;
    e_b_d     = e_b_q;
    e_op_d    = e_op_q;
    e_rob_d   = e_rob_q;
    val_d     = val_q;
    rob_d     = rob_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q | (valid_in && !accept);

    if (e_adv) begin
      val_d[wr_ptr_q] = result;
      rob_d[wr_ptr_q] = e_rob_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(e_adv) - CW'(pop);

    if (accept) begin
      e_valid_d = 1'b1;
      e_a_d     = rval1_in;
      e_b_d     = rval2_in;
      e_op_d    = opcode_in;
      e_rob_d   = rob_ix_in;
    end else if (e_adv) begin
      e_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      e_valid_q <= 1'b0;
      e_a_q     <= '0;
      e_b_q     <= '0;
      e_op_q    <= '0;
      e_rob_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        val_q[i] <= '0;
        rob_q[i] <= '0;
      end
    end else begin
      e_valid_q <= e_valid_d;
      e_a_q     <= e_a_d;
      e_b_q     <= e_b_d;
      e_op_q    <= e_op_d;
      e_rob_q   <= e_rob_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      val_q     <= val_d;
      rob_q     <= rob_d;
    end
  end
endmodule

// File: tb/tb_alu_functional_unit.sv
// tb/tb_alu_functional_unit.sv - directed self-checking bench for alu_functional_unit
module tb_alu_functional_unit;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [31:0] rval1_in, rval2_in;
  logic [3:0]  opcode_in;
  logic [2:0]  rob_ix_in;
  logic        busy_out, cdb_req_out, cdb_grant_in, overflow_err_out;
  logic [2:0]  cdb_rob_ix_out;
  logic [31:0] cdb_value_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] sweep_exp [16];

  alu_functional_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
    .rval1_in(rval1_in), .rval2_in(rval2_in), .opcode_in(opcode_in), .rob_ix_in(rob_ix_in),
    .busy_out(busy_out), .cdb_req_out(cdb_req_out), .cdb_grant_in(cdb_grant_in),
    .cdb_rob_ix_out(cdb_rob_ix_out), .cdb_value_out(cdb_value_out),
    .overflow_err_out(overflow_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic beat(input logic [2:0] rob, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    valid_in  = 1'b1;
    rob_ix_in = rob;
    rval1_in  = a;
    rval2_in  = b;
    opcode_in = op;
  endtask

  initial begin
    sweep_exp[0] = 32'h80000004; sweep_exp[1] = 32'h7FFFFFFC; sweep_exp[2] = 32'h0;
    sweep_exp[3] = 32'h80000004; sweep_exp[4] = 32'h80000004; sweep_exp[5] = 32'h1;
    sweep_exp[6] = 32'h0;        sweep_exp[7] = 32'h0;        sweep_exp[8] = 32'h08000000;
    sweep_exp[9] = 32'hF8000000;
    for (int i = 10; i < 16; i++) sweep_exp[i] = 32'h0;

    rst_in = 1'b1; valid_in = 1'b0; rval1_in = '0; rval2_in = '0;
    opcode_in = '0; rob_ix_in = '0; cdb_grant_in = 1'b0;
    #12;
    check("rst_req", cdb_req_out, 0);
    check("rst_val", cdb_value_out, 0);
    check("rst_rob", cdb_rob_ix_out, 0);
    check("rst_ovf", overflow_err_out, 0);
    check("rst_busy", busy_out, 0);
    rst_in = 1'b0;
    step();

    // basic add: result visible exactly one cycle, two cycles after input edge
    cdb_grant_in = 1'b1;
    beat(3'd5, 32'd7, -32'sd3, 4'd0);
    #1 check("add_busy", busy_out, 0);
    step(); valid_in = 1'b0;
    check("add_req_e", cdb_req_out, 0);
    step();
    check("add_req", cdb_req_out, 1);
    check("add_val", cdb_value_out, 32'd4);
    check("add_rob", cdb_rob_ix_out, 5);
    step();
    check("add_req_off", cdb_req_out, 0);

    // opcode sweep
    for (int i = 0; i < 16; i++) begin
      beat(3'(i), 32'h80000000, 32'h00000004, 4'(i));
      step(); valid_in = 1'b0;
      step();
      check($sformatf("sweep_val_%0d", i), cdb_value_out, sweep_exp[i]);
      check($sformatf("sweep_rob_%0d", i), cdb_rob_ix_out, 32'(i % 8));
    end
    step();
    check("sweep_drain", cdb_req_out, 0);

    // back-pressure with grant low
    cdb_grant_in = 1'b0;
    beat(3'd1, 32'd1, 32'd1, 4'd0);
    #1 check("bp_busy0", busy_out, 0);
    step(); valid_in = 1'b0;
    #1 check("bp_busy1", busy_out, 0);
    step();
    beat(3'd2, 32'd10, 32'd10, 4'd0);
    #1 check("bp_busy_rise", busy_out, 1);
    step(); valid_in = 1'b0;
    #1 check("bp_busy_e", busy_out, 1);
    step();
    check("bp_busy_full", busy_out, 1);
    check("bp_head_rob", cdb_rob_ix_out, 1);
    check("bp_head_val", cdb_value_out, 2);
    step();
    check("bp_hold_rob", cdb_rob_ix_out, 1);
    cdb_grant_in = 1'b1;
    step();
    check("bp_busy_fall", busy_out, 0);
    check("bp_pop2_rob", cdb_rob_ix_out, 2);
    check("bp_pop2_val", cdb_value_out, 20);
    step();
    check("bp_empty", cdb_req_out, 0);

    // full FIFO plus held E, then simultaneous push/pop
    cdb_grant_in = 1'b0;
    beat(3'd1, 32'd100, 32'd1, 4'd0); step(); valid_in = 1'b0; step();
    beat(3'd2, 32'd200, 32'd2, 4'd0); step(); valid_in = 1'b0; step();
    beat(3'd3, 32'd300, 32'd3, 4'd0); step(); valid_in = 1'b0;
    check("full_head", cdb_rob_ix_out, 1);
    check("full_busy", busy_out, 1);
    cdb_grant_in = 1'b1;
    step();
    cdb_grant_in = 1'b0;
    check("pp_head", cdb_rob_ix_out, 2);
    check("pp_count2", busy_out, 1);
    check("pp_ovf", overflow_err_out, 0);

    // forced overflow: FIFO full, E valid, grant low
    beat(3'd4, 32'd400, 32'd4, 4'd0); step();
    beat(3'd5, 32'd500, 32'd5, 4'd0); step(); valid_in = 1'b0;
    check("ovf_set", overflow_err_out, 1);
    step(); step();
    check("ovf_sticky", overflow_err_out, 1);
    cdb_grant_in = 1'b1;
    check("ovf_d2_rob", cdb_rob_ix_out, 2);
    check("ovf_d2_val", cdb_value_out, 202);
    step();
    check("ovf_d3_rob", cdb_rob_ix_out, 3);
    check("ovf_d3_val", cdb_value_out, 303);
    step();
    check("ovf_d4_rob", cdb_rob_ix_out, 4);
    check("ovf_d4_val", cdb_value_out, 404);
    step();
    check("ovf_drained", cdb_req_out, 0);
    check("ovf_still", overflow_err_out, 1);

    // reset mid-flight
    cdb_grant_in = 1'b0;
    beat(3'd6, 32'd6, 32'd0, 4'd0); step(); valid_in = 1'b0; step();
    beat(3'd7, 32'd7, 32'd0, 4'd0); step(); valid_in = 1'b0; step();
    check("rf_queued", cdb_req_out, 1);
    #3 rst_in = 1'b1;
    #1 check("rf_req_drop", cdb_req_out, 0);
    check("rf_ovf_clr", overflow_err_out, 0);
    rst_in = 1'b0;
    cdb_grant_in = 1'b1;
    step();
    check("rf_no_stale", cdb_req_out, 0);
    beat(3'd3, 32'd9, 32'd4, 4'd1);
    step(); valid_in = 1'b0;
    check("rf_lat1", cdb_req_out, 0);
    step();
    check("rf_req", cdb_req_out, 1);
    check("rf_val", cdb_value_out, 5);
    check("rf_rob", cdb_rob_ix_out, 3);
    step();
    check("rf_done", cdb_req_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
